// File: rtl/led_pattern_gen.sv
// led_pattern_gen: animated LED pattern generator for the DE2-115 LED banks.
// Steps one of several patterns (off/on/blink/chase/bounce/count) at a prescaled rate.
//
// Ports:
//   CLK_50  in   system clock, all logic on its rising edge
//   RESET   in   synchronous active-high reset
//   MODE    in   pattern select: 0 off, 1 on, 2 blink, 3 chase, 4 bounce, 5 count, 6/7 off
//   PAUSE   in   freezes the prescaler and the pattern while high
//   LEDS    out  registered LED drive, 1 = lit
//   STEP    out  one-cycle pulse, high in the cycle LEDS shows a new step value
module led_pattern_gen #(
  parameter int NUM_LEDS = 18,
  parameter int PRESCALE = 12_500_000
) (
  input  logic                CLK_50,
  input  logic                RESET,
  input  logic [2:0]          MODE,
  input  logic                PAUSE,
  output logic [NUM_LEDS-1:0] LEDS,
  output logic                STEP
);

  localparam int CW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CW-1:0] CNT_MAX =
    CW'(PRESCALE - 1);

  localparam logic [NUM_LEDS-1:0] LED_ONE =
    NUM_LEDS'(1);

  typedef enum logic [2:0] {
    M_OFF    = 3'd0,
    M_ON     = 3'd1,
    M_BLINK  = 3'd2,
    M_CHASE  = 3'd3,
    M_BOUNCE = 3'd4,
    M_COUNT  = 3'd5,
    M_RES6   = 3'd6,
    M_RES7   = 3'd7
  } mode_e;

  mode_e               mode_q, mode_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                step_q, step_d;

  logic                mode_chg;
  logic                tick;
  logic [NUM_LEDS-1:0] init_pat;
  logic [NUM_LEDS-1:0] adv_pat;
  logic                adv_dir;

  assign mode_chg = (MODE != mode_q);

  // A mode change swallows a coincident tick.
  assign tick = !PAUSE
             && (cnt_q == CNT_MAX)
             && !mode_chg;

  // Pattern shown immediately on entering a mode.
  always_comb begin
    init_pat = '0;
    case (mode_e'(MODE))
      M_ON,
      M_BLINK:  init_pat = '1;
      M_CHASE,
      M_BOUNCE: init_pat = LED_ONE;
      default:  init_pat = '0;
    endcase
  end

  // Pattern and direction after one step of the current mode.
  always_comb begin
    adv_pat = leds_q;
    adv_dir = dir_q;
    case (mode_q)
      M_ON:    adv_pat = '1;
      M_BLINK: adv_pat = ~leds_q;
      M_CHASE: adv_pat = {leds_q[NUM_LEDS-2:0],
                          leds_q[NUM_LEDS-1]};
      M_BOUNCE: begin
        // Turn around on reaching an end so each
        // end bit is lit for exactly one step.
        if (dir_q && leds_q[NUM_LEDS-1]) begin
          adv_dir = 1'b0;
          adv_pat = leds_q >> 1;
        end else if (!dir_q && leds_q[0]) begin
          adv_dir = 1'b1;
          adv_pat = leds_q << 1;
        end else if (dir_q) begin
          adv_pat = leds_q << 1;
        end else begin
          adv_pat = leds_q >> 1;
        end
      end
      M_COUNT: adv_pat = leds_q + LED_ONE;
      default: adv_pat = '0;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    leds_d = leds_q;
    step_d = 1'b0;
    if (mode_chg) begin
      mode_d = mode_e'(MODE);
      cnt_d  = '0;
      dir_d  = 1'b1;
      leds_d = init_pat;
    end else if (tick) begin
      cnt_d  = '0;
      dir_d  = adv_dir;
      leds_d = adv_pat;
      step_d = 1'b1;
    end else if (!PAUSE) begin
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      mode_q <= M_OFF;
      cnt_q  <= '0;
      dir_q  <= 1'b1;
      leds_q <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      leds_q <= leds_d;
      step_q <= step_d;
    end
  end

  assign LEDS = leds_q;
  assign STEP = step_q;

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator for the DE2-115 LED banks. It drives an N-bit LED vector with one of several selectable animated patterns: off, all-on, blink, chase, bounce and binary count. A built-in prescaler divides CLK_50 down to a visible step rate. One instance drives LEDR (N=18) and another drives LEDG (N=8) from the board top level.

## Interface
- NUM_LEDS, 18, width of the LED vector; legal range ≥ 2.
- PRESCALE, 12_500_000, CLK_50 cycles per pattern step (4 Hz at 50 MHz); legal range ≥ 1.

- CLK_50  input  1  system clock. One clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- MODE  input  3  pattern select: 0 off, 1 all-on, 2 blink, 3 chase, 4 bounce, 5 count, 6/7 off.
- PAUSE  input  1  while high, the prescaler and pattern freeze and LEDS holds.
- LEDS  output  NUM_LEDS  registered LED drive; 1 = lit.
- STEP  output  1  one-cycle pulse, high in the same cycle LEDS shows a new step value.

## Operation
- Internal state:
  - mode_q (3 b), the registered MODE.
  - cnt (prescale counter), width clog2(PRESCALE), minimum 1 bit.
  - dir (bounce direction, 1 = toward MSB).
- Reset (RESET=1 at an edge): LEDS=0, STEP=0, cnt=0, mode_q=0, dir=1. Reset overrides every other input, including in the middle of a pattern.
- Mode change (MODE != mode_q at an edge, not in reset):
  - mode_q ← MODE, cnt ← 0, STEP ← 0, dir ← 1.
  - LEDS ← initial pattern of the new mode.
  - Mode change takes priority over a coincident tick; no step occurs that cycle. It is applied even when PAUSE=1.
- Initial patterns: off 0; all-on all 1s; blink all 1s; chase 1 (bit0 only); bounce 1; count 0; modes 6/7 give 0.
- Tick:
  - Asserted when PAUSE=0, cnt == PRESCALE-1, and there is no mode change.
  - On tick, cnt ← 0; otherwise cnt ← cnt+1 while PAUSE=0. cnt holds while PAUSE=1.
- Step actions on tick (STEP ← 1 for all modes, including off and all-on):
  - off / 6 / 7: LEDS stays 0.
  - all-on: LEDS stays all 1s.
  - blink: LEDS ← ~LEDS.
  - chase: rotate left by 1; bit N-1 wraps to bit0.
  - bounce:
    - If dir=1 and LEDS[N-1]=1: dir ← 0, shift right.
    - If dir=0 and LEDS[0]=1: dir ← 1, shift left.
    - Otherwise shift in direction dir.
    - Exactly one bit is lit at all times. End bits are lit for one step each, with no repeat.
  - count: LEDS ← LEDS+1 modulo 2^NUM_LEDS; all 1s wraps to 0.
- STEP ← 0 on every non-tick cycle.
- PAUSE has no effect on a pending mode change. Releasing PAUSE resumes from the held cnt value.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Mode change to initial pattern: LEDS is updated at the first edge where MODE differs from mode_q, i.e. 1-cycle latency.
- Step period: exactly PRESCALE cycles between STEP pulses while unpaused with constant MODE.
  - The first step comes PRESCALE edges after a mode change or reset-exit mode load.
- PRESCALE=1: tick on every unpaused cycle; STEP is held high continuously.
- MODE held at a non-zero value through reset: at the first edge after RESET falls, mode_q loads MODE and the initial pattern appears.
- Pause: a cycle in which PAUSE=1 produces no tick and does not advance cnt. Each paused cycle extends the current step by exactly one cycle.

## Test plan
All directed tests use NUM_LEDS=4, PRESCALE=4.
- Reset: drive MODE=3, RESET=1 for 3 cycles. LEDS=0000 and STEP=0 throughout. At the first edge after release LEDS=0001. Then LEDS=0010 four edges later, then 0100, 1000, 0001, with STEP high exactly on each change.
- Bounce: MODE=4 from an idle (off) state. Sequence is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, with one step every 4 cycles and no repeated end value.
- Count wrap: MODE=5 for 17 steps. LEDS goes 0000…1111, then 0000, then 0001. Blink check: MODE=2 gives 1111, 0000, 1111.
- Pause: in chase mode at LEDS=0010 with cnt=2, hold PAUSE=1 for 10 cycles. LEDS and cnt are frozen and STEP=0. After release, the next step (0100) arrives 2 cycles later.
- Mode change on a tick cycle: switch MODE 5→3 on the edge where cnt=3. LEDS=0001, STEP=0, and the next step comes 4 cycles later. Also switch to MODE=7: LEDS=0000, with STEP pulsing every 4 cycles.
- Reset mid-pattern: assert RESET during bounce with dir=0. LEDS=0 at the next edge. With MODE still 4 after release, LEDS=0001 and it moves toward the MSB.
